// File: rtl/stream_proc_fifo.sv
// stream_proc_fifo: write-side transform stage feeding a register-array FIFO,
// with a threshold/error interrupt, a full flag and sticky overflow/underflow flags.
module stream_proc_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 512,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_arg,
  input  logic [AW:0]       cfg_thresh,
  input  logic              cfg_intr_en,
  input  logic              clr_err,
  input  logic              fifo_wren,
  input  logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_rden,
  output logic [DATA_W-1:0] fifo_rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       data_count,
  output logic              ovf,
  output logic              udf,
  output logic              intr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    MODE_INV  = 3'd0,
    MODE_ADD  = 3'd1,
    MODE_PASS = 3'd2,
    MODE_XOR  = 3'd3,
    MODE_BREV = 3'd4,
    MODE_INC  = 3'd5
  } mode_t;

  // Byte-order reversal for any DATA_W that is a multiple of 8
  function automatic logic [DATA_W-1:0] byte_reverse(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W/8; i++) begin
      r[i*8 +: 8] = d[DATA_W-8-i*8 +: 8];
    end
    return r;
  endfunction

  // Runtime-selected word transform; unused mode codes pass data through
  function automatic logic [DATA_W-1:0] transform(input logic [2:0]        mode,
                                                  input logic [DATA_W-1:0] d,
                                                  input logic [DATA_W-1:0] arg);
    logic [DATA_W-1:0] r;
    case (mode)
      MODE_INV:  r = ~d;
      MODE_ADD:  r = d + arg;
      MODE_PASS: r = d;
      MODE_XOR:  r = d ^ arg;
      MODE_BREV: r = byte_reverse(d);
      MODE_INC:  r = d + DATA_W'(1);
      default:   r = d;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              stage_valid;
  logic [DATA_W-1:0] stage_data;
  logic              rd_accept;
  logic              commit;
  logic              drop;
  logic              udf_event;
  logic              level_hit;

  // A read frees a slot in the same cycle, so a full FIFO can still accept a commit
  assign rd_accept  = fifo_rden & ~empty;
  assign commit     = stage_valid & ((count != DEPTH_C) | rd_accept);
  assign drop       = stage_valid & ~commit;
  assign udf_event  = fifo_rden & empty;
  assign level_hit  = (count >= cfg_thresh) & (cfg_thresh != '0);

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign data_count = count;

  // Stage 1: capture the transformed word together with the config seen on the write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= fifo_wren;
      if (fifo_wren) begin
        stage_data <= transform(cfg_mode, fifo_wr_data, cfg_arg);
      end
    end
  end

  // Storage array has no reset; validity is tracked entirely by the pointers and count
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wr_ptr] <= stage_data;
    end
  end

  // Write pointer advances on every committed word and wraps modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (commit) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Read side: head word is registered out and held until the next accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      fifo_rd_data <= '0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy: simultaneous commit and read leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({commit, rd_accept})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= drop      | (ovf & ~clr_err);
      udf <= udf_event | (udf & ~clr_err);
    end
  end

  // Level interrupt registered one cycle behind its sources
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr <= 1'b0;
    end else begin
      intr <= cfg_intr_en & (level_hit | ovf | udf);
    end
  end

endmodule

// File: tb/tb_stream_proc_fifo.sv
// Directed scoreboard bench for stream_proc_fifo (DATA_W=32, DEPTH=512).
module tb_stream_proc_fifo;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cfg_mode;
  logic [31:0] cfg_arg;
  logic [9:0]  cfg_thresh;
  logic        cfg_intr_en;
  logic        clr_err;
  logic        fifo_wren;
  logic [31:0] fifo_wr_data;
  logic        fifo_rden;
  logic [31:0] fifo_rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [9:0]  data_count;
  logic        ovf;
  logic        udf;
  logic        intr;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_data;

  stream_proc_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_mode     (cfg_mode),
    .cfg_arg      (cfg_arg),
    .cfg_thresh   (cfg_thresh),
    .cfg_intr_en  (cfg_intr_en),
    .clr_err      (clr_err),
    .fifo_wren    (fifo_wren),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rden    (fifo_rden),
    .fifo_rd_data (fifo_rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .data_count   (data_count),
    .ovf          (ovf),
    .udf          (udf),
    .intr         (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] model(input logic [2:0] m, input logic [31:0] d, input logic [31:0] a);
    case (m)
      3'd0:    return ~d;
      3'd1:    return d + a;
      3'd3:    return d ^ a;
      3'd4:    return {d[7:0], d[15:8], d[23:16], d[31:24]};
      3'd5:    return d + 32'd1;
      default: return d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe; the expected result is queued only if it should be stored
  task automatic applyStimulus(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d,
                               input bit store);
    cfg_mode     = m;
    cfg_arg      = a;
    fifo_wr_data = d;
    fifo_wren    = 1'b1;
    if (store) sb.push_back(model(m, d, a));
    tick();
    fifo_wren = 1'b0;
  endtask

  // One-cycle read strobe on a non-empty FIFO; result compared against scoreboard head
  task automatic readWord(input string tag);
    logic [31:0] e;
    fifo_rden = 1'b1;
    tick();
    fifo_rden = 1'b0;
    checkOutput({tag, "_valid"}, 32'(rd_valid), 32'd1);
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("[TB] FAIL %s_sb observed=emptyqueue expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_data"}, fifo_rd_data, e);
      last_data = e;
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_mode = '0; cfg_arg = '0; cfg_thresh = '0; cfg_intr_en = 1'b0;
    clr_err = 1'b0; fifo_wren = 1'b0; fifo_wr_data = '0; fifo_rden = 1'b0;
    last_data = '0;
    repeat (3) tick();
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_count", 32'(data_count), 32'd0);
    checkOutput("rst_rdvalid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rddata", fifo_rd_data, 32'd0);
    checkOutput("rst_err", {30'd0, ovf, udf}, 32'd0);
    checkOutput("rst_intr", 32'(intr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: invert, write-to-empty latency, single read
    applyStimulus(3'd0, 32'd0, 32'h0000_0000, 1'b0);
    sb.push_back(32'hFFFF_FFFF);
    checkOutput("t1_empty_1clk", 32'(empty), 32'd1);
    tick();
    checkOutput("t1_empty_2clk", 32'(empty), 32'd0);
    readWord("t1_rd");
    checkOutput("t1_empty_after", 32'(empty), 32'd1);
    tick();
    checkOutput("t1_valid_drop", 32'(rd_valid), 32'd0);
    checkOutput("t1_data_hold", fifo_rd_data, 32'hFFFF_FFFF);

    // Test 2: add with wrap, byte reverse
    applyStimulus(3'd1, 32'd5, 32'hFFFF_FFFE, 1'b0);
    sb.push_back(32'h0000_0003);
    applyStimulus(3'd4, 32'd0, 32'h1122_3344, 1'b0);
    sb.push_back(32'h4433_2211);
    tick();
    checkOutput("t2_count", 32'(data_count), 32'd2);
    readWord("t2_add");
    readWord("t2_brev");

    // Test 3: fill, overflow, drain, underflow, error clearing
    for (int k = 0; k < 512; k++) begin
      applyStimulus(3'(k), 32'h5A5A_0000 | 32'(k), $urandom, 1'b1);
      checkOutput("t3_count_fill", 32'(data_count), 32'(k));
    end
    tick();
    checkOutput("t3_count_full", 32'(data_count), 32'd512);
    checkOutput("t3_full", 32'(full), 32'd1);
    applyStimulus(3'd2, 32'd0, 32'hDEAD_BEEF, 1'b0);
    checkOutput("t3_ovf_pre", 32'(ovf), 32'd0);
    tick();
    checkOutput("t3_ovf", 32'(ovf), 32'd1);
    checkOutput("t3_count_ovf", 32'(data_count), 32'd512);
    for (int k = 0; k < 512; k++) readWord("t3_drain");
    checkOutput("t3_empty", 32'(empty), 32'd1);
    fifo_rden = 1'b1;
    tick();
    fifo_rden = 1'b0;
    checkOutput("t3_udf_valid", 32'(rd_valid), 32'd0);
    checkOutput("t3_udf", 32'(udf), 32'd1);
    checkOutput("t3_udf_count", 32'(data_count), 32'd0);
    checkOutput("t3_udf_hold", fifo_rd_data, last_data);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("t3_clr", {30'd0, ovf, udf}, 32'd0);
    fifo_rden = 1'b1;
    tick();
    clr_err = 1'b1;
    tick();
    fifo_rden = 1'b0;
    checkOutput("t3_setwins", 32'(udf), 32'd1);
    tick();
    clr_err = 1'b0;
    checkOutput("t3_clr2", 32'(udf), 32'd0);

    // Test 4: full FIFO with read and commit in the same cycle
    for (int k = 0; k < 512; k++) applyStimulus(3'd2, 32'd0, 32'(k) * 32'h0001_0003, 1'b1);
    tick();
    checkOutput("t4_full", 32'(full), 32'd1);
    applyStimulus(3'd2, 32'd0, 32'hCAFE_F00D, 1'b1);
    readWord("t4_rw");
    checkOutput("t4_ovf", 32'(ovf), 32'd0);
    checkOutput("t4_count", 32'(data_count), 32'd512);
    for (int k = 0; k < 512; k++) readWord("t4_drain");
    checkOutput("t4_last", last_data, 32'hCAFE_F00D);
    checkOutput("t4_empty", 32'(empty), 32'd1);
    checkOutput("t4_ovf_end", 32'(ovf), 32'd0);

    // Test 5: threshold interrupt
    cfg_thresh = 10'd4;
    cfg_intr_en = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(3'd2, 32'd0, 32'hA0 + 32'(k), 1'b1);
    tick();
    checkOutput("t5_count4", 32'(data_count), 32'd4);
    checkOutput("t5_intr_lag", 32'(intr), 32'd0);
    tick();
    checkOutput("t5_intr_rise", 32'(intr), 32'd1);
    readWord("t5_rd");
    checkOutput("t5_count3", 32'(data_count), 32'd3);
    checkOutput("t5_intr_hold", 32'(intr), 32'd1);
    tick();
    checkOutput("t5_intr_fall", 32'(intr), 32'd0);
    applyStimulus(3'd2, 32'd0, 32'hA4, 1'b1);
    tick();
    tick();
    checkOutput("t5_intr_again", 32'(intr), 32'd1);
    cfg_intr_en = 1'b0;
    tick();
    checkOutput("t5_intr_mask", 32'(intr), 32'd0);
    for (int k = 0; k < 4; k++) readWord("t5_drain");

    // Test 6: reset with data stored and a write in flight
    cfg_intr_en = 1'b1;
    for (int k = 0; k < 10; k++) applyStimulus(3'd2, 32'd0, 32'hB0 + 32'(k), 1'b1);
    applyStimulus(3'd2, 32'd0, 32'hBB, 1'b0);
    checkOutput("t6_count10", 32'(data_count), 32'd10);
    checkOutput("t6_intr_pre", 32'(intr), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_empty", 32'(empty), 32'd1);
    checkOutput("t6_count", 32'(data_count), 32'd0);
    checkOutput("t6_full", 32'(full), 32'd0);
    checkOutput("t6_rdvalid", 32'(rd_valid), 32'd0);
    checkOutput("t6_rddata", fifo_rd_data, 32'd0);
    checkOutput("t6_err", {30'd0, ovf, udf}, 32'd0);
    checkOutput("t6_intr", 32'(intr), 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("t6_post_empty", 32'(empty), 32'd1);
    checkOutput("t6_post_count", 32'(data_count), 32'd0);
    checkOutput("t6_post_intr", 32'(intr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
